dpram_sc_be: RTL
================

DPRAM_SC_BE -- requirements
Module: dpram_sc_be

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, address bits per port; depth = 2**ADDR_WIDTH words.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, word width, legal 8..1152.
REQ-003 SHALL have parameter BYTE_SIZE, default 8, legal 8 or 9; BE_WIDTH = ceil(DATA_WIDTH/BYTE_SIZE), derived; top lane may be partial.
REQ-004 SHALL have parameters A_WRITE_MODE and B_WRITE_MODE, default "TRANSPARENT_WRITE" and "NORMAL_WRITE", legal "NORMAL_WRITE", "TRANSPARENT_WRITE", "READ_BEFORE_WRITE".
REQ-005 SHALL have parameter OUTPUT_REG, default 0, legal 0 or 1; 1 adds one output pipeline stage on both ports.
REQ-006 clk  input  1  single clock for both ports; all logic on rising edge.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 a_en, b_en  input  1 each  port access enable; no access when low.
REQ-009 a_wr_en, b_wr_en  input  1 each  write when high with x_en, read otherwise.
REQ-010 a_byte_en, b_byte_en  input  BE_WIDTH each  per-lane write enable; ignored on reads.
REQ-011 a_addr, b_addr  input  ADDR_WIDTH each  word address.
REQ-012 a_wr_data, b_wr_data  input  DATA_WIDTH each  write data.
REQ-013 a_rd_data, b_rd_data  output  DATA_WIDTH each  read data.
REQ-014 a_rd_valid, b_rd_valid  output  1 each  one-cycle pulse qualifying x_rd_data.
REQ-015 collision  output  1  pulse, same-address access conflict (present only with macro, see Configuration).
REQ-016 collision_cnt  output  16  saturating conflict count (present only with macro).

Function
REQ-017 Read (x_en=1, x_wr_en=0): x_rd_data SHALL show mem[x_addr] with x_rd_valid=1 exactly 1 cycle later (OUTPUT_REG=0) or 2 cycles later (OUTPUT_REG=1).
REQ-018 Write: lanes with x_byte_en[i]=1 SHALL be updated; lanes with 0 SHALL retain content; all-zero byte_en SHALL leave word unchanged.
REQ-019 Own-port write result: NORMAL_WRITE -- x_rd_data holds previous value, x_rd_valid stays 0; TRANSPARENT_WRITE -- merged new word, x_rd_valid=1; READ_BEFORE_WRITE -- old word, x_rd_valid=1; same latency as REQ-017.
REQ-020 x_rd_data SHALL hold its last value whenever x_rd_valid=0.
REQ-021 Both ports write same address same cycle: port A lanes SHALL win per lane where a_byte_en=1; port B lanes SHALL apply only where a_byte_en=0.
REQ-022 One port writes, other reads same address same cycle: reader SHALL receive the pre-write word.
REQ-023 Different addresses SHALL never interact; two simultaneous reads of same address SHALL both return mem contents.
REQ-024 With OUTPUT_REG=1 the read pipeline SHALL accept a new access every cycle (throughput 1/cycle/port), valid and data advancing together.

Reset
REQ-025 rst_n low SHALL asynchronously clear a_rd_data, b_rd_data, a_rd_valid, b_rd_valid, all pipeline stages, collision and collision_cnt to 0.
REQ-026 Memory array SHALL NOT be reset; contents survive rst_n.
REQ-027 Accesses in flight when rst_n asserts SHALL be discarded (no valid pulse after release); writes sampled on the reset edge SHALL not occur.

Configuration
REQ-028 Macro DPRAM_SC_BE_COLLISION_DET_EN defined: collision SHALL pulse 1 cycle after both ports enabled, same address, at least one writing; collision_cnt SHALL increment per such cycle, saturating at 16'hFFFF.
REQ-029 Macro undefined: collision and collision_cnt ports and logic SHALL be absent; REQ-021/022 arbitration unchanged.

Verification
REQ-030 OUTPUT_REG=0: A writes 16'hBEEF @0x005 be=2'b11, then B reads 0x005 -> b_rd_data=16'hBEEF, b_rd_valid=1 one cycle after read.
REQ-031 A writes 16'h1234 @0x010, then A writes 16'hAB00 be=2'b10 @0x010 (TRANSPARENT) -> a_rd_data=16'hAB34 next cycle, a_rd_valid=1.
REQ-032 Same cycle A writes 16'h1111 be=2'b01, B writes 16'h2222 be=2'b11 @0x3FF -> later read returns 16'h2211; with macro collision=1, collision_cnt=1.
REQ-033 mem[0x020]=16'h00AA; same cycle A writes 16'h5555 @0x020, B reads 0x020 -> b_rd_data=16'h00AA; subsequent B read -> 16'h5555.
REQ-034 OUTPUT_REG=1: back-to-back B reads 0x000..0x003 -> four consecutive valid pulses, data in order, first 2 cycles after first read.
REQ-035 Read issued, rst_n pulsed low next cycle -> rd_valid=0, rd_data=0; memory word read after release unchanged.

Source files
------------

// File: rtl/dpram_sc_be.sv
// True dual-port RAM, single clock, per-lane byte enables, per-port write modes.
// Optional collision detector/counter enabled by defining DPRAM_SC_BE_COLLISION_DET_EN.
module dpram_sc_be #(
  parameter int    ADDR_WIDTH   = 10,
  parameter int    DATA_WIDTH   = 16,
  parameter int    BYTE_SIZE    = 8,
  parameter string A_WRITE_MODE = "TRANSPARENT_WRITE",
  parameter string B_WRITE_MODE = "NORMAL_WRITE",
  parameter int    OUTPUT_REG   = 0,
  localparam int   BE_WIDTH     = (DATA_WIDTH + BYTE_SIZE - 1) / BYTE_SIZE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_en,
  input  logic                  a_wr_en,
  input  logic [BE_WIDTH-1:0]   a_byte_en,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wr_data,
  output logic [DATA_WIDTH-1:0] a_rd_data,
  output logic                  a_rd_valid,
  input  logic                  b_en,
  input  logic                  b_wr_en,
  input  logic [BE_WIDTH-1:0]   b_byte_en,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wr_data,
  output logic [DATA_WIDTH-1:0] b_rd_data,
  output logic                  b_rd_valid
`ifdef DPRAM_SC_BE_COLLISION_DET_EN
  ,
  output logic                  collision,
  output logic [15:0]           collision_cnt
`endif
);

  // 0 = normal, 1 = transparent, 2 = read-before-write
  localparam int A_MODE = (A_WRITE_MODE == "NORMAL_WRITE")      ? 0 :
                          (A_WRITE_MODE == "READ_BEFORE_WRITE") ? 2 : 1;
  localparam int B_MODE = (B_WRITE_MODE == "NORMAL_WRITE")      ? 0 :
                          (B_WRITE_MODE == "READ_BEFORE_WRITE") ? 2 : 1;

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  function automatic logic [DATA_WIDTH-1:0] lane_mask(input logic [BE_WIDTH-1:0] be);
    logic [DATA_WIDTH-1:0] m;
    m = '0;
    for (int j = 0; j < DATA_WIDTH; j++) m[j] = be[j / BYTE_SIZE];
    return m;
  endfunction

  logic                  a_rd, a_we, b_rd, b_we, same_addr, a_wins;
  logic [DATA_WIDTH-1:0] a_mask, b_mask;
  logic [DATA_WIDTH-1:0] a_old, b_old, a_new, b_base, b_new, a_final;

  assign a_rd      = a_en & ~a_wr_en;
  assign b_rd      = b_en & ~b_wr_en;
  assign a_we      = a_en & a_wr_en & rst_n;
  assign b_we      = b_en & b_wr_en & rst_n;
  assign same_addr = (a_addr == b_addr);
  assign a_wins    = same_addr & a_we;

  assign a_old  = mem[a_addr];
  assign b_old  = mem[b_addr];
  assign a_mask = lane_mask(a_byte_en);
  // Port B only owns the lanes port A leaves alone on a shared address.
  assign b_mask = lane_mask(b_byte_en) & ~(a_wins ? a_mask : '0);

  assign a_new   = (a_old & ~a_mask) | (a_wr_data & a_mask);
  assign b_base  = a_wins ? a_new : b_old;
  assign b_new   = (b_base & ~b_mask) | (b_wr_data & b_mask);
  assign a_final = (same_addr & b_we) ? b_new : a_new;

  // On a shared address b_new already carries A's lanes, so its later write is the final word.
  always_ff @(posedge clk) begin
    if (a_we) mem[a_addr] <= a_new;
    if (b_we) mem[b_addr] <= b_new;
  end

  logic                  a_v0, b_v0, a_v1, b_v1;
  logic [DATA_WIDTH-1:0] a_d0, b_d0, a_d1, b_d1;

  always_comb begin
    a_v0 = a_rd;
    a_d0 = a_old;
    if (a_we) begin
      case (A_MODE)
        0:       a_v0 = 1'b0;
        1:       begin a_v0 = 1'b1; a_d0 = a_final; end
        default: a_v0 = 1'b1;
      endcase
    end
  end

  always_comb begin
    b_v0 = b_rd;
    b_d0 = b_old;
    if (b_we) begin
      case (B_MODE)
        0:       b_v0 = 1'b0;
        1:       begin b_v0 = 1'b1; b_d0 = b_new; end
        default: b_v0 = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_v1 <= 1'b0;
      a_d1 <= '0;
      b_v1 <= 1'b0;
      b_d1 <= '0;
    end else begin
      a_v1 <= a_v0;
      b_v1 <= b_v0;
      if (a_v0) a_d1 <= a_d0;
      if (b_v0) b_d1 <= b_d0;
    end
  end

  generate
    if (OUTPUT_REG != 0) begin : g_oreg
      logic                  a_v2, b_v2;
      logic [DATA_WIDTH-1:0] a_d2, b_d2;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_v2 <= 1'b0;
          a_d2 <= '0;
          b_v2 <= 1'b0;
          b_d2 <= '0;
        end else begin
          a_v2 <= a_v1;
          b_v2 <= b_v1;
          if (a_v1) a_d2 <= a_d1;
          if (b_v1) b_d2 <= b_d1;
        end
      end
      assign a_rd_valid = a_v2;
      assign a_rd_data  = a_d2;
      assign b_rd_valid = b_v2;
      assign b_rd_data  = b_d2;
    end else begin : g_noreg
      assign a_rd_valid = a_v1;
      assign a_rd_data  = a_d1;
      assign b_rd_valid = b_v1;
      assign b_rd_data  = b_d1;
    end
  endgenerate

`ifdef DPRAM_SC_BE_COLLISION_DET_EN
  logic coll_now;
  assign coll_now = a_en & b_en & same_addr & (a_wr_en | b_wr_en);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      collision     <= 1'b0;
      collision_cnt <= '0;
    end else begin
      collision <= coll_now;
      if (coll_now && collision_cnt != 16'hFFFF) collision_cnt <= collision_cnt + 16'd1;
    end
  end
`endif

endmodule
